nvme_fifo_pack: RTL and testbench

- Upstream feeder for nvme_fifo.
- Accepts a narrow valid/ready beat stream with a last marker, packs `ratio` beats into one wide entry, and pushes that entry into nvme_fifo.
- Uses the FIFO's registered almost_full as backpressure, because nvme_fifo silently discards pushes while full.
- Sits between the NVMe data-path source (e.g. PCIe completion payload) and the buffering FIFO.

---
 rtl/nvme_pack_pkg.sv | 29 ++
 rtl/nvme_pack_timer.sv | 32 +++
 rtl/nvme_fifo_pack.sv | 131 +++++++++++++
 tb/tb_nvme_fifo_pack.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvme_pack_pkg.sv
// nvme_pack_pkg: state encoding and fifo_din field offsets
// shared by the nvme_fifo beat packer files.
package nvme_pack_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int count_lsb(
    input int iwidth,
    input int ratio
  );
    return iwidth * ratio;
  endfunction

  function automatic int last_bit(
    input int iwidth,
    input int ratio,
    input int cwidth
  );
    return iwidth * ratio + cwidth;
  endfunction

endpackage

// File: rtl/nvme_pack_timer.sv
// nvme_pack_timer: saturating idle counter for the packer,
// pulses expire when a held partial entry has aged out.
module nvme_pack_timer #(
  parameter int timeout = 64,
  parameter int twidth  = $clog2(timeout + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [twidth-1:0] last_cnt =
    twidth'(timeout - 1);
  localparam logic [twidth-1:0] max_cnt = '1;

  logic [twidth-1:0] cnt_q;

  assign expire = run & (cnt_q == last_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run && cnt_q != max_cnt) begin
      cnt_q <= cnt_q + twidth'(1);
    end
  end

endmodule

// File: rtl/nvme_fifo_pack.sv
// nvme_fifo_pack: packs narrow beats into wide nvme_fifo entries.
// Define NVME_PACK_TIMEOUT_EN to flush aged partial entries.
module nvme_fifo_pack
  import nvme_pack_pkg::*;
#(
  parameter int iwidth  = 32,
  parameter int ratio   = 4,
  parameter int cwidth  = $clog2(ratio + 1),
  parameter int owidth  = 1 + cwidth + iwidth * ratio,
  parameter int timeout = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [iwidth-1:0] in_data,
  input  logic              in_last,
  input  logic              flush,
  input  logic              fifo_almost_full,
  output logic              fifo_push,
  output logic [owidth-1:0] fifo_din,
  output logic              partial
);

  localparam int dwidth = iwidth * ratio;

  function automatic logic [owidth-1:0] pack_entry(
    input logic              last,
    input logic [cwidth-1:0] cnt,
    input logic [dwidth-1:0] data
  );
    logic [owidth-1:0] e;
    e = '0;
    e[last_bit(iwidth, ratio, cwidth)] = last;
    e[count_lsb(iwidth, ratio) +: cwidth] = cnt;
    e[data_lsb() +: dwidth] = data;
    return e;
  endfunction

  state_t            state_q, state_d;
  logic [cwidth-1:0] idx_q, idx_d, idx_inc;
  logic [dwidth-1:0] acc_q, acc_d, slots;
  logic [owidth-1:0] din_q, din_d;
  logic              push_q, push_d;
  logic              accept, done, expire;

  assign in_ready = ~fifo_almost_full & ~flush;
  assign accept   = in_valid & in_ready;
  assign idx_inc  = idx_q + cwidth'(1);
  assign done     = in_last |
                    (idx_q == cwidth'(ratio - 1));

  always_comb begin
    slots = acc_q;
    slots[idx_q * iwidth +: iwidth] = in_data;
  end

`ifdef NVME_PACK_TIMEOUT_EN
  logic run, clear;
  assign run   = (state_q == FILL) & ~accept;
  assign clear = accept | flush | expire;

  nvme_pack_timer #(
    .timeout (timeout)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .run    (run),
    .expire (expire)
  );
`else
  logic unused_timeout;
  assign expire = 1'b0;
  assign unused_timeout = ^timeout;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    din_d   = din_q;
    push_d  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
      acc_d   = '0;
    end else if (accept) begin
      if (done) begin
        din_d   = pack_entry(in_last, idx_inc, slots);
        push_d  = 1'b1;
        acc_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        acc_d   = slots;
        idx_d   = idx_inc;
        state_d = FILL;
      end
    end else if (expire) begin
      // aged-out partial: short entry, not end of transfer
      din_d   = pack_entry(1'b0, idx_q, acc_q);
      push_d  = 1'b1;
      acc_d   = '0;
      idx_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      din_q   <= '0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      din_q   <= din_d;
      push_q  <= push_d;
    end
  end

  // a flush in the push cycle must not reach the fifo
  assign fifo_push = push_q & ~flush;
  assign fifo_din  = din_q;
  assign partial   = (state_q == FILL);

endmodule

// File: tb/tb_nvme_fifo_pack.sv
// tb_nvme_fifo_pack: directed self-checking bench for the packer
// (iwidth=8, ratio=4, timeout=8).
module tb_nvme_fifo_pack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        flush = 1'b0;
  logic        fifo_almost_full = 1'b0;
  logic        fifo_push;
  logic [35:0] fifo_din;
  logic        partial;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int sent_cyc = 0;
  logic tb_full = 1'b0;
  logic [35:0] pq[$];
  int pc[$];

  nvme_fifo_pack #(
    .iwidth  (8),
    .ratio   (4),
    .timeout (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_last          (in_last),
    .flush            (flush),
    .fifo_almost_full (fifo_almost_full),
    .fifo_push        (fifo_push),
    .fifo_din         (fifo_din),
    .partial          (partial)
  );

  always #5 clk = ~clk;

  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (fifo_push === 1'b1) begin
      pq.push_back(fifo_din);
      pc.push_back(cyc);
      total++;
      if (tb_full)
        $display("FAIL push_while_full: push=1 required 0");
      else
        passed++;
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    sent_cyc = cyc;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  task automatic clear_q();
    pq.delete();
    pc.delete();
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (fifo_push !== 1'b0)
      $display("FAIL rst_push: got %b required 0", fifo_push);
    else passed++;
    total++;
    if (fifo_din !== 36'h0)
      $display("FAIL rst_din: got %h required 0", fifo_din);
    else passed++;
    total++;
    if (partial !== 1'b0)
      $display("FAIL rst_partial: got %b required 0", partial);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL rst_ready: got %b required 1", in_ready);
    else passed++;
  endtask

  task automatic test_full_entry();
    clear_q();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    repeat (3) @(negedge clk);
    total++;
    if (pq.size() !== 1)
      $display("FAIL full_cnt: got %0d required 1", pq.size());
    else passed++;
    if (pq.size() > 0) begin
      total++;
      if (pq[0] !== 36'hC_44332211)
        $display("FAIL full_din: got %h required %h",
                 pq[0], 36'hC_44332211);
      else passed++;
      total++;
      if (pc[0] !== sent_cyc + 1)
        $display("FAIL full_lat: got %0d required %0d",
                 pc[0], sent_cyc + 1);
      else passed++;
    end
  endtask

  task automatic test_short();
    clear_q();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    repeat (2) @(negedge clk);
    total++;
    if (pq.size() !== 1)
      $display("FAIL short_cnt: got %0d required 1", pq.size());
    else passed++;
    if (pq.size() > 0) begin
      total++;
      if (pq[0] !== 36'hA_0000BBAA)
        $display("FAIL short_din: got %h required %h",
                 pq[0], 36'hA_0000BBAA);
      else passed++;
    end
    total++;
    if (partial !== 1'b0)
      $display("FAIL short_idle: got %b required 0", partial);
    else passed++;
  endtask

  task automatic test_back_to_back();
    clear_q();
    for (int i = 1; i <= 8; i++)
      send(8'(i), i == 8);
    repeat (2) @(negedge clk);
    total++;
    if (pq.size() !== 2)
      $display("FAIL b2b_cnt: got %0d required 2", pq.size());
    else passed++;
    if (pq.size() == 2) begin
      total++;
      if (pq[0] !== 36'h4_04030201)
        $display("FAIL b2b_din0: got %h required %h",
                 pq[0], 36'h4_04030201);
      else passed++;
      total++;
      if (pq[1] !== 36'hC_08070605)
        $display("FAIL b2b_din1: got %h required %h",
                 pq[1], 36'hC_08070605);
      else passed++;
      total++;
      if (pc[1] - pc[0] !== 4)
        $display("FAIL b2b_gap: got %0d required 4",
                 pc[1] - pc[0]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    clear_q();
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    fifo_almost_full = 1'b1;
    tb_full  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h63;
    #1;
    total++;
    if (in_ready !== 1'b0)
      $display("FAIL bp_ready: got %b required 0", in_ready);
    else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (partial !== 1'b1)
      $display("FAIL bp_partial: got %b required 1", partial);
    else passed++;
    total++;
    if (pq.size() !== 0)
      $display("FAIL bp_hold: got %0d required 0", pq.size());
    else passed++;
    fifo_almost_full = 1'b0;
    tb_full = 1'b0;
    send(8'h63, 1'b0);
    send(8'h64, 1'b0);
    send(8'h65, 1'b0);
    send(8'h66, 1'b1);
    repeat (2) @(negedge clk);
    total++;
    if (pq.size() !== 2)
      $display("FAIL bp_cnt: got %0d required 2", pq.size());
    else passed++;
    if (pq.size() == 2) begin
      total++;
      if (pq[0] !== 36'h4_64636261)
        $display("FAIL bp_din0: got %h required %h",
                 pq[0], 36'h4_64636261);
      else passed++;
      total++;
      if (pq[1] !== 36'hA_00006665)
        $display("FAIL bp_din1: got %h required %h",
                 pq[1], 36'hA_00006665);
      else passed++;
    end
  endtask

  task automatic test_flush();
    clear_q();
    send(8'h71, 1'b0);
    send(8'h72, 1'b0);
    send(8'h73, 1'b0);
    total++;
    if (partial !== 1'b1)
      $display("FAIL fl_partial: got %b required 1", partial);
    else passed++;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    total++;
    if (in_ready !== 1'b0)
      $display("FAIL fl_ready: got %b required 0", in_ready);
    else passed++;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    total++;
    if (partial !== 1'b0)
      $display("FAIL fl_clear: got %b required 0", partial);
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (pq.size() !== 0)
      $display("FAIL fl_nopush: got %0d required 0", pq.size());
    else passed++;
    send(8'h81, 1'b0);
    send(8'h82, 1'b0);
    send(8'h83, 1'b0);
    send(8'h84, 1'b1);
    repeat (2) @(negedge clk);
    total++;
    if (pq.size() !== 1 || pq[0] !== 36'hC_84838281)
      $display("FAIL fl_clean: got %0d entries %h required 1 %h",
               pq.size(), pq.size() > 0 ? pq[0] : 36'h0,
               36'hC_84838281);
    else passed++;
  endtask

  task automatic test_flush_pending();
    clear_q();
    send(8'h91, 1'b0);
    send(8'h92, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (pq.size() !== 0)
      $display("FAIL flp_kill: got %0d required 0", pq.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    clear_q();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    reset = 1'b1;
    #1;
    total++;
    if (partial !== 1'b0)
      $display("FAIL rm_partial: got %b required 0", partial);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (pq.size() !== 0)
      $display("FAIL rm_nopush: got %0d required 0", pq.size());
    else passed++;
  endtask

`ifdef NVME_PACK_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    clear_q();
    send(8'h5A, 1'b0);
    k = sent_cyc;
    repeat (12) @(negedge clk);
    total++;
    if (pq.size() !== 1)
      $display("FAIL to_cnt: got %0d required 1", pq.size());
    else passed++;
    if (pq.size() > 0) begin
      total++;
      if (pq[0] !== 36'h1_0000005A)
        $display("FAIL to_din: got %h required %h",
                 pq[0], 36'h1_0000005A);
      else passed++;
      total++;
      if (pc[0] !== k + 9)
        $display("FAIL to_lat: got %0d required %0d",
                 pc[0], k + 9);
      else passed++;
    end
    total++;
    if (partial !== 1'b0)
      $display("FAIL to_idle: got %b required 0", partial);
    else passed++;
    clear_q();
    send(8'h5B, 1'b0);
    repeat (7) @(negedge clk);
    send(8'h5C, 1'b1);
    repeat (12) @(negedge clk);
    total++;
    if (pq.size() !== 1 || pq[0] !== 36'hA_00005C5B)
      $display("FAIL to_race: got %0d entries %h required 1 %h",
               pq.size(), pq.size() > 0 ? pq[0] : 36'h0,
               36'hA_00005C5B);
    else passed++;
  endtask
`else
  task automatic test_timeout();
    clear_q();
    send(8'h5A, 1'b0);
    repeat (80) @(negedge clk);
    total++;
    if (pq.size() !== 0)
      $display("FAIL nto_hold: got %0d required 0", pq.size());
    else passed++;
    total++;
    if (partial !== 1'b1)
      $display("FAIL nto_partial: got %b required 1", partial);
    else passed++;
    send(8'h5B, 1'b1);
    repeat (2) @(negedge clk);
    total++;
    if (pq.size() !== 1 || pq[0] !== 36'hA_00005B5A)
      $display("FAIL nto_done: got %0d entries %h required 1 %h",
               pq.size(), pq.size() > 0 ? pq[0] : 36'h0,
               36'hA_00005B5A);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_full_entry();
    test_short();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_flush_pending();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
